instr_encoder: RTL

//  Builds 16-bit ISA words from opcode/format/register/immediate fields, range-checked, then queued for issue.

---
 rtl/instr_encoder_pkg.sv | 70 +++++++
 rtl/instr_encoder_if.sv | 26 ++
 rtl/instr_encoder_fifo.sv | 46 ++++
 rtl/instr_encoder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// enc_pkg: shared types and constants for the instruction encoder.
//   fmt_e       format codes carried on in_fmt
//   req_t       latched request fields
//   E_*         err_code values, lowest number wins when several apply
//   *_MIN/*_MAX immediate range limits per format
//   immir_code  maps the RIR immediate set {1,2,4,8,-8,-4,-2,-1} to {hit,code}
// Format code 6 is the halt slot. It is usable only when INSTR_ENC_HLT_GUARD_EN
// is defined and is illegal otherwise. RIR uses code 7.
package enc_pkg;

  typedef enum logic [2:0] {
    F_S13  = 3'd0,
    F_S10  = 3'd1,
    F_RRR  = 3'd2,
    F_RI7  = 3'd3,
    F_RI7U = 3'd4,
    F_RI4  = 3'd5,
    F_HLT  = 3'd6,
    F_RIR  = 3'd7
  } fmt_e;

  typedef struct packed {
    fmt_e        fmt;
    logic [5:0]  opc;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rt;
    logic [15:0] imm;
  } req_t;

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_IMM   = 3'd1;
  localparam logic [2:0] E_REG   = 3'd2;
  localparam logic [2:0] E_TGT   = 3'd3;
  localparam logic [2:0] E_IMMIR = 3'd4;
  localparam logic [2:0] E_FMT   = 3'd5;
  localparam logic [2:0] E_SHORT = 3'd6;
  localparam logic [2:0] E_HALT  = 3'd7;

  // word layout: bit15 selects short/long, opcode sits above the operand field
  localparam int LONG_BIT = 15;
  localparam int SOPC_LSB = 13;
  localparam int LOPC_LSB = 9;

  localparam logic signed [15:0] S13_MIN = -16'sd4096;
  localparam logic signed [15:0] S13_MAX =  16'sd4095;
  localparam logic signed [15:0] S10_MIN = -16'sd512;
  localparam logic signed [15:0] S10_MAX =  16'sd511;
  localparam logic signed [15:0] S7_MIN  = -16'sd64;
  localparam logic signed [15:0] S7_MAX  =  16'sd63;
  localparam logic signed [15:0] U7_MAX  =  16'sd127;
  localparam logic signed [15:0] U4_MAX  =  16'sd15;

  localparam logic [15:0] HALT_WORD = 16'hfe00;

  function automatic logic [3:0] immir_code(input logic [15:0] imm);
    case (imm)
      16'h0001: immir_code = 4'b1_000;
      16'h0002: immir_code = 4'b1_001;
      16'h0004: immir_code = 4'b1_010;
      16'h0008: immir_code = 4'b1_011;
      16'hfff8: immir_code = 4'b1_100;
      16'hfffc: immir_code = 4'b1_101;
      16'hfffe: immir_code = 4'b1_110;
      16'hffff: immir_code = 4'b1_111;
      default:  immir_code = 4'b0_000;
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request and issue handshakes of the encoder.
//   in_*  request side (valid/ready plus fields)
//   out_* issue side (valid/ready plus encoded word)
// master = producer/consumer environment, slave = encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [5:0]  in_opc;
  logic [3:0]  in_ra;
  logic [3:0]  in_rb;
  logic [3:0]  in_rt;
  logic [15:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;

  modport master (
    output in_valid, in_fmt, in_opc, in_ra, in_rb, in_rt, in_imm, out_ready,
    input  in_ready, out_valid, out_instr
  );
  modport slave (
    input  in_valid, in_fmt, in_opc, in_ra, in_rb, in_rt, in_imm, out_ready,
    output in_ready, out_valid, out_instr
  );
endinterface

// File: rtl/instr_encoder_fifo.sv
// enc_fifo: DEPTH x W output queue, valid/ready on both sides.
//   in_valid/in_ready/in_data     push side; a push is allowed while full if a pop happens in the same cycle
//   out_valid/out_ready/out_data  pop side; out_data reads 0 when empty
// DEPTH must be a power of two and at least 2.
module enc_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         full, empty, push, pop;

  // extra pointer bit separates full from empty
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid = !empty;
  assign in_ready  = !full || out_ready;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: builds 16-bit ISA words from request fields, range-checks
// them and queues them for issue.
//   clk, reset          clock and synchronous active-high reset
//   bus (slave)         request handshake in, encoded word handshake out
//   err                 1-cycle pulse when a request is rejected
//   err_code            reason for the last rejection, held until the next one
//   n_issued, n_err     saturating counts of popped words and rejected requests
// Build option INSTR_ENC_HLT_GUARD_EN: reject any word equal to the halt word
// (code 7) unless the request uses F_HLT, which emits the halt word directly.
module instr_encoder
  import enc_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  instr_encoder_if.slave   bus,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] n_issued,
  output logic [CNT_W-1:0] n_err
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  logic [1:0]         state;
  req_t               req;
  logic [15:0]        word;
  logic [2:0]         code;
  logic               ok, pop, fifo_in_valid, fifo_in_ready;
  logic               bad_imm, bad_reg, bad_tgt, bad_immir, bad_fmt, bad_short;
  logic               ir_hit;
  logic [2:0]         ir_code;
  logic signed [15:0] simm;
  logic [3:0]         rt_m1;

  assign simm  = req.imm;
  assign rt_m1 = req.rt - 4'd1;

  // encode and check the latched request; fields stay put through STALL
  always_comb begin
    word      = '0;
    bad_imm   = 1'b0;
    bad_reg   = 1'b0;
    bad_tgt   = 1'b0;
    bad_immir = 1'b0;
    bad_fmt   = 1'b0;
    bad_short = 1'b0;
    {ir_hit, ir_code} = immir_code(req.imm);
    case (req.fmt)
      F_S13: begin
        bad_imm   = (simm < S13_MIN) || (simm > S13_MAX);
        bad_short = |req.opc[5:2];
        word      = {1'b0, req.opc[1:0], req.imm[12:0]};
      end
      F_S10: begin
        bad_imm   = (simm < S10_MIN) || (simm > S10_MAX);
        bad_reg   = req.rt[3];
        bad_short = |req.opc[5:2];
        word      = {1'b0, req.opc[1:0], req.imm[9:0], req.rt[2:0]};
      end
      F_RRR: begin
        bad_reg = req.ra[3] || req.rb[3] || req.rt[3];
        word    = {1'b1, req.opc, req.ra[2:0], req.rb[2:0], req.rt[2:0]};
      end
      F_RI7: begin
        bad_imm = (simm < S7_MIN) || (simm > S7_MAX);
        bad_tgt = (req.rt < 4'd1) || (req.rt > 4'd4);
        word    = {1'b1, req.opc, req.imm[6:0], rt_m1[1:0]};
      end
      F_RI7U: begin
        bad_imm = (simm < 16'sd0) || (simm > U7_MAX);
        bad_tgt = (req.rt < 4'd1) || (req.rt > 4'd4);
        word    = {1'b1, req.opc, req.imm[6:0], rt_m1[1:0]};
      end
      F_RI4: begin
        bad_imm = (simm < 16'sd0) || (simm > U4_MAX);
        bad_reg = req.rt[3];
        word    = {1'b1, req.opc, req.imm[3:0], 2'b00, req.rt[2:0]};
      end
      F_RIR: begin
        bad_reg   = req.rb[3] || req.rt[3];
        bad_immir = !ir_hit;
        word      = {1'b1, req.opc, ir_code, req.rb[2:0], req.rt[2:0]};
      end
      F_HLT: begin
`ifdef INSTR_ENC_HLT_GUARD_EN
        word = HALT_WORD;
`else
        bad_fmt = 1'b1;
`endif
      end
      default: bad_fmt = 1'b1;
    endcase

    if      (bad_imm)   code = E_IMM;
    else if (bad_reg)   code = E_REG;
    else if (bad_tgt)   code = E_TGT;
    else if (bad_immir) code = E_IMMIR;
    else if (bad_fmt)   code = E_FMT;
    else if (bad_short) code = E_SHORT;
`ifdef INSTR_ENC_HLT_GUARD_EN
    else if (word == HALT_WORD && req.fmt != F_HLT) code = E_HALT;
`endif
    else                code = E_NONE;
  end

  assign ok            = (code == E_NONE);
  assign bus.in_ready  = (state == S_IDLE) && !reset;
  assign fifo_in_valid = (state != S_IDLE) && ok;
  assign pop           = bus.out_valid && bus.out_ready;

  enc_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (fifo_in_valid),
    .in_ready  (fifo_in_ready),
    .in_data   (word),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (bus.out_instr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      req      <= '0;
      err      <= 1'b0;
      err_code <= E_NONE;
      n_issued <= '0;
      n_err    <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: if (bus.in_valid) begin
          req   <= '{fmt: fmt_e'(bus.in_fmt), opc: bus.in_opc, ra: bus.in_ra,
                     rb: bus.in_rb, rt: bus.in_rt, imm: bus.in_imm};
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (!ok) begin
            err      <= 1'b1;
            err_code <= code;
            state    <= S_IDLE;
          end else if (fifo_in_ready) begin
            state <= S_IDLE;
          end else begin
            state <= S_STALL;
          end
        end
        S_STALL: if (fifo_in_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (pop && n_issued != '1) n_issued <= n_issued + CNT_W'(1);
      if (state == S_CHECK && !ok && n_err != '1) n_err <= n_err + CNT_W'(1);
    end
  end
endmodule
